// File: rtl/nasti_stream_pkg.sv
// nasti_stream_pkg
// Shared definitions for the NASTI-Stream arbiter slice:
//   idx_w()      - width of a source index for n inputs (at least 1 bit)
//   arb_state_t  - arbiter FSM state encoding
//   beat_t       - packed beat layout at the default widths; modules with
//                  their own widths declare a local struct of the same shape.
package nasti_stream_pkg;

    localparam int DEF_ID_WIDTH   = 1;
    localparam int DEF_DEST_WIDTH = 1;
    localparam int DEF_USER_WIDTH = 1;
    localparam int DEF_DATA_WIDTH = 64;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                        last;
        logic [DEF_DATA_WIDTH-1:0]   data;
        logic [DEF_DATA_WIDTH/8-1:0] strb;
        logic [DEF_DATA_WIDTH/8-1:0] keep;
        logic [DEF_ID_WIDTH-1:0]     id;
        logic [DEF_DEST_WIDTH-1:0]   dest;
        logic [DEF_USER_WIDTH-1:0]   user;
    } beat_t;

endpackage

// File: rtl/nasti_stream_buf.sv
// nasti_stream_buf
// Two-entry FIFO / register slice with full throughput. The output payload
// comes straight from the head register, and in_ready depends only on the
// occupancy, never on out_ready.
// Ports:
//   clk, rstn            - clock, synchronous active-low reset
//   in_valid/in_ready    - push handshake, in_data [W-1:0]
//   out_valid/out_ready  - pop handshake, out_data [W-1:0]
module nasti_stream_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   count;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;

    assign in_ready  = rstn & (count != 2'd2);
    assign out_valid = rstn & (count != 2'd0);
    assign out_data  = head;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload is left unreset; count alone decides what is live.
    // Push with pop at count 2 cannot occur because in_ready is low there.
    always_ff @(posedge clk) begin
        if (pop) begin
            if (count == 2'd2)
                head <= tail;
            else if (push)
                head <= in_data;
        end else if (push) begin
            if (count == 2'd0)
                head <= in_data;
            else
                tail <= in_data;
        end
    end

endmodule

// File: rtl/nasti_stream_arbiter.sv
// nasti_stream_arbiter
// N-to-1 NASTI-Stream merge with round-robin arbitration. With LOCK_PACKET=1
// a grant is held from the first beat of a packet to its t_last beat. Each
// output beat carries its source index above the original t_id.
// Ports:
//   clk, rstn                         - clock, synchronous active-low reset
//   s_t_* [N_CHANNEL-1:0][...]        - slave stream inputs (ready is output)
//   m_t_*                             - master stream output, registered
//   m_t_id [MID_WIDTH-1:0]            - {source index, s_t_id}
module nasti_stream_arbiter
    import nasti_stream_pkg::*;
#(
    parameter int N_CHANNEL   = 4,
    parameter int ID_WIDTH    = 1,
    parameter int DEST_WIDTH  = 1,
    parameter int USER_WIDTH  = 1,
    parameter int DATA_WIDTH  = 64,
    parameter int LOCK_PACKET = 1,
    localparam int IDX_W      = idx_w(N_CHANNEL),
    localparam int MID_WIDTH  = ID_WIDTH + IDX_W,
    localparam int KW         = DATA_WIDTH / 8
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [N_CHANNEL-1:0]                  s_t_valid,
    output logic [N_CHANNEL-1:0]                  s_t_ready,
    input  logic [N_CHANNEL-1:0]                  s_t_last,
    input  logic [N_CHANNEL-1:0][DATA_WIDTH-1:0]  s_t_data,
    input  logic [N_CHANNEL-1:0][KW-1:0]          s_t_strb,
    input  logic [N_CHANNEL-1:0][KW-1:0]          s_t_keep,
    input  logic [N_CHANNEL-1:0][ID_WIDTH-1:0]    s_t_id,
    input  logic [N_CHANNEL-1:0][DEST_WIDTH-1:0]  s_t_dest,
    input  logic [N_CHANNEL-1:0][USER_WIDTH-1:0]  s_t_user,
    output logic                                  m_t_valid,
    input  logic                                  m_t_ready,
    output logic                                  m_t_last,
    output logic [DATA_WIDTH-1:0]                 m_t_data,
    output logic [KW-1:0]                         m_t_strb,
    output logic [KW-1:0]                         m_t_keep,
    output logic [MID_WIDTH-1:0]                  m_t_id,
    output logic [DEST_WIDTH-1:0]                 m_t_dest,
    output logic [USER_WIDTH-1:0]                 m_t_user
);

    typedef struct packed {
        logic [MID_WIDTH-1:0]  id;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
        logic [KW-1:0]         strb;
        logic [KW-1:0]         keep;
    } mbeat_t;

    arb_state_t        state, state_nx;
    logic [IDX_W-1:0]  rr_ptr, rr_nx;
    logic [IDX_W-1:0]  lock_idx, lock_nx;
    logic [IDX_W-1:0]  grant;
    logic              grant_valid;
    logic [IDX_W:0]    picked;
    logic              buf_ready;
    logic              accept;
    mbeat_t            in_beat;
    mbeat_t            out_beat;

    // First valid input strictly after ptr, wrapping. The loop runs from the
    // lowest priority down so the last hit is the winner.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_CHANNEL-1:0] v,
                                               input logic [IDX_W-1:0]     ptr);
        logic [IDX_W:0] r;
        int             j;
        r = '0;
        for (int k = N_CHANNEL; k >= 1; k--) begin
            j = (int'(ptr) + k) % N_CHANNEL;
            if (v[j]) r = {1'b1, IDX_W'(j)};
        end
        return r;
    endfunction

    always_comb begin
        picked = rr_pick(s_t_valid, rr_ptr);
        if (state == ST_LOCKED) begin
            // Locked input keeps the grant even while its valid is low.
            grant_valid = 1'b1;
            grant       = lock_idx;
        end else begin
            grant_valid = picked[IDX_W];
            grant       = picked[IDX_W-1:0];
        end
    end

    // buf_ready already folds in rstn and the full condition.
    always_comb begin
        for (int i = 0; i < N_CHANNEL; i++)
            s_t_ready[i] = grant_valid & (grant == IDX_W'(i)) & buf_ready;
    end

    assign accept = |(s_t_valid & s_t_ready);

    always_comb begin
        in_beat.id   = {grant, s_t_id[grant]};
        in_beat.dest = s_t_dest[grant];
        in_beat.user = s_t_user[grant];
        in_beat.last = s_t_last[grant];
        in_beat.data = s_t_data[grant];
        in_beat.strb = s_t_strb[grant];
        in_beat.keep = s_t_keep[grant];
    end

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        lock_nx  = lock_idx;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    rr_nx = grant;
                    if (!s_t_last[grant] && (LOCK_PACKET != 0)) begin
                        state_nx = ST_LOCKED;
                        lock_nx  = grant;
                    end
                end
            end
            ST_LOCKED: begin
                if (accept && s_t_last[grant]) begin
                    state_nx = ST_IDLE;
                    rr_nx    = grant;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // rr_ptr resets to the last input so input 0 is searched first.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            rr_ptr   <= IDX_W'(N_CHANNEL - 1);
            lock_idx <= '0;
        end else begin
            state    <= state_nx;
            rr_ptr   <= rr_nx;
            lock_idx <= lock_nx;
        end
    end

    nasti_stream_buf #(
        .W ($bits(mbeat_t))
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (accept),
        .in_ready  (buf_ready),
        .in_data   (in_beat),
        .out_valid (m_t_valid),
        .out_ready (m_t_ready),
        .out_data  (out_beat)
    );

    assign m_t_id   = out_beat.id;
    assign m_t_dest = out_beat.dest;
    assign m_t_user = out_beat.user;
    assign m_t_last = out_beat.last;
    assign m_t_data = out_beat.data;
    assign m_t_strb = out_beat.strb;
    assign m_t_keep = out_beat.keep;

endmodule
